// File: rtl/hermes_tx_framer.sv
// hermes_tx_framer: credit-handshaked output FIFO with Hermes packet framing markers.
module hermes_tx_framer #(
   parameter int HERMES_FLIT_SIZE = 32,
   parameter int BUFFER_SIZE = 8,
   parameter int PKT_CNT_WIDTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          rx_i,
   output logic                          credit_o,
   input  logic [HERMES_FLIT_SIZE-1:0]   data_i,
   output logic                          tx_o,
   input  logic                          credit_i,
   output logic [HERMES_FLIT_SIZE-1:0]   data_o,
   output logic                          sop_o,
   output logic                          eop_o,
   output logic [PKT_CNT_WIDTH-1:0]      pkt_count_o,
   output logic [$clog2(BUFFER_SIZE):0]  occupancy_o,
   output logic                          busy_o
);
   localparam int AW = $clog2(BUFFER_SIZE);
   typedef enum logic [1:0] {HDR, SIZE, PAYLOAD} state_t;
   logic [HERMES_FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] occ_q, occ_d;
   state_t state_q, state_d;
   logic [31:0] rem_q, rem_d;
   logic [PKT_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic push, pop, last;
   assign credit_o = occ_q != (AW+1)'(BUFFER_SIZE);
   assign tx_o = occ_q != '0;
   assign data_o = mem_q[rd_ptr_q];
   assign push = rx_i && credit_o;
   assign pop = tx_o && credit_i;
   assign occupancy_o = occ_q;
   assign pkt_count_o = cnt_q;
   assign busy_o = tx_o || state_q != HDR;
   // last marks the final flit of a packet: a zero size flit or the last payload flit
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
      last = state_q == SIZE ? data_o == '0 : state_q == PAYLOAD && rem_q == 32'd1;
      sop_o = tx_o && state_q == HDR;
      eop_o = tx_o && last;
      state_d = state_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      if (pop) begin
         state_d = last ? HDR : state_q == HDR ? SIZE : PAYLOAD;
         rem_d = state_q == SIZE ? 32'(data_o) : state_q == PAYLOAD ? rem_q - 32'd1 : rem_q;
         cnt_d = last ? cnt_q + 1'b1 : cnt_q;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q <= '0;
         state_q <= HDR;
         rem_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q <= occ_d;
         state_q <= state_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk_i) if (push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: tb/tb_hermes_tx_framer.sv
// tb_hermes_tx_framer: scoreboard bench for hermes_tx_framer.
module tb_hermes_tx_framer;
   localparam int PCW = 8;
   typedef struct {logic [31:0] d; logic s; logic e;} exp_t;
   logic clk = 0, rst_i = 1, rx_i = 0, credit_i = 0;
   logic [31:0] data_i = '0;
   logic credit_o, tx_o, sop_o, eop_o, busy_o;
   logic [31:0] data_o;
   logic [PCW-1:0] pkt_count_o;
   logic [3:0] occupancy_o;
   int tests = 0, fails = 0;
   logic run = 0, allow_drop = 0;
   exp_t sb [$];
   int mst = 0;
   logic [31:0] mrem = 0;
   logic [PCW-1:0] exp_pkts = 0;
   hermes_tx_framer #(.HERMES_FLIT_SIZE(32), .BUFFER_SIZE(8), .PKT_CNT_WIDTH(PCW)) dut (
      .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .credit_o(credit_o), .data_i(data_i),
      .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o),
      .pkt_count_o(pkt_count_o), .occupancy_o(occupancy_o), .busy_o(busy_o)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Reference framing of the input stream, computed as each flit is offered
   task automatic model_push(input logic [31:0] d);
      exp_t e;
      e.d = d;
      e.s = mst == 0;
      e.e = 0;
      if (mst == 0) mst = 1;
      else if (mst == 1) begin
         e.e = d == 0;
         if (d == 0) begin mst = 0; exp_pkts++; end
         else begin mrem = d; mst = 2; end
      end else begin
         e.e = mrem == 1;
         mrem--;
         if (mrem == 0) begin mst = 0; exp_pkts++; end
      end
      sb.push_back(e);
   endtask
   task automatic model_reset();
      sb.delete();
      mst = 0;
      mrem = 0;
      exp_pkts = 0;
   endtask
   task automatic send(input logic [31:0] d);
      int n = 0;
      while (!credit_o && n < 200) begin @(posedge clk); #1; n++; end
      if (!credit_o) check("send_timeout", 0, 1);
      else begin
         model_push(d);
         rx_i = 1;
         data_i = d;
         @(posedge clk); #1;
         rx_i = 0;
      end
   endtask
   task automatic drain();
      int n = 0;
      while (busy_o && n < 400) begin @(posedge clk); #1; n++; end
      check("drain_busy", busy_o, 0);
      check("sb_left", sb.size(), 0);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (run && !rst_i) begin
         if (rx_i && !credit_o && !allow_drop) check("proto_push_full", 1, 0);
         check("occ_bound", occupancy_o <= 8, 1);
         if (!tx_o) begin
            check("sop_idle", sop_o, 0);
            check("eop_idle", eop_o, 0);
         end else if (credit_i) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
               e = sb.pop_front();
               check("data", data_o, e.d);
               check("sop", sop_o, e.s);
               check("eop", eop_o, e.e);
            end
         end
      end
   end
   initial begin
      logic done;
      int cnt;
      logic [31:0] sz;
      repeat (2) @(posedge clk);
      #1 rst_i = 0;
      run = 1;
      check("rst_tx", tx_o, 0);
      check("rst_credit", credit_o, 1);
      check("rst_occ", occupancy_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_sop", sop_o, 0);
      check("rst_eop", eop_o, 0);
      check("rst_pkt", pkt_count_o, 0);
      credit_i = 1;
      model_push(32'h101);
      rx_i = 1;
      data_i = 32'h101;
      check("no_fallthrough", tx_o, 0);
      @(posedge clk); #1;
      rx_i = 0;
      check("lat_tx", tx_o, 1);
      check("lat_occ", occupancy_o, 1);
      send(32'h2); send(32'hA); send(32'hB);
      drain();
      check("pkt1", pkt_count_o, exp_pkts);
      send(32'h0202); send(32'h0);
      drain();
      check("pkt_zero", pkt_count_o, exp_pkts);
      credit_i = 0;
      send(32'h0303); send(32'd6);
      for (int i = 0; i < 6; i++) send(32'hC0 + i);
      check("full_occ", occupancy_o, 8);
      check("full_credit", credit_o, 0);
      allow_drop = 1;
      rx_i = 1;
      data_i = 32'hDEAD;
      credit_i = 1;
      @(posedge clk); #1;
      rx_i = 0;
      allow_drop = 0;
      check("nobypass_occ", occupancy_o, 7);
      check("nobypass_credit", credit_o, 1);
      drain();
      check("pkt_full", pkt_count_o, exp_pkts);
      done = 0;
      cnt = 0;
      credit_i = 0;
      fork
         begin
            while (cnt < 64) begin
               send($urandom);
               sz = $urandom_range(0, 4);
               send(sz);
               cnt += 2;
               for (int i = 0; i < int'(sz); i++) begin send($urandom); cnt++; end
            end
            done = 1;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            while (!done) begin
               credit_i = $urandom_range(0, 1);
               @(posedge clk); #1;
            end
         end
      join
      credit_i = 1;
      drain();
      check("pkt_stream", pkt_count_o, exp_pkts);
      send(32'h0404); send(32'd4); send(32'hE0);
      credit_i = 0;
      send(32'hE1);
      rst_i = 1;
      @(posedge clk); #1;
      rst_i = 0;
      model_reset();
      check("mid_rst_tx", tx_o, 0);
      check("mid_rst_occ", occupancy_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_pkt", pkt_count_o, 0);
      credit_i = 1;
      send(32'h0505); send(32'h0);
      drain();
      check("post_rst_pkt", pkt_count_o, exp_pkts);
      while (exp_pkts != '1) begin send(32'h0606); send(32'h0); end
      drain();
      check("pkt_allones", pkt_count_o, {PCW{1'b1}});
      send(32'h0707); send(32'h0);
      drain();
      check("pkt_wrap", pkt_count_o, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
